vx_mem_arb_wrr: RTL

- Parametrised successor to the fixed 2-input round-robin L1 memory arbiter that merges icache/dcache traffic onto the socket memory bus.
- Generalises to NUM_INPUTS requesters with per-input weighted round-robin bursts and per-input outstanding-read limits.
- Appends the input index into tag LSBs and routes responses back by those bits.
- Sits between per-socket L1 caches and the L2/memory bus.

---
 rtl/vx_mem_arb_wrr.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/vx_mem_arb_wrr.sv
// vx_mem_arb_wrr: N-input weighted round-robin L1->L2 memory arbiter.
// Optional perf counters: define VX_MEM_ARB_PERF_EN.
module vx_mem_arb_wrr #(
  parameter int NUM_INPUTS   = 4,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_SIZE    = 64,
  parameter int TAG_WIDTH    = 8,
  parameter int MAX_PENDING  = 8,
  parameter int WEIGHT_WIDTH = 3,
  localparam int LOG_N = $clog2(NUM_INPUTS),
  localparam int OTW   = TAG_WIDTH + LOG_N,
  localparam int DW    = DATA_SIZE * 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weights,
  input  logic [NUM_INPUTS-1:0]              in_req_valid,
  output logic [NUM_INPUTS-1:0]              in_req_ready,
  input  logic [NUM_INPUTS-1:0]              in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_INPUTS*DW-1:0]           in_req_data,
  input  logic [NUM_INPUTS*DATA_SIZE-1:0]    in_req_byteen,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]    in_req_tag,
  output logic [NUM_INPUTS-1:0]              in_rsp_valid,
  input  logic [NUM_INPUTS-1:0]              in_rsp_ready,
  output logic [DW-1:0]                      in_rsp_data,
  output logic [TAG_WIDTH-1:0]               in_rsp_tag,
  output logic                               out_req_valid,
  input  logic                               out_req_ready,
  output logic                               out_req_rw,
  output logic [ADDR_WIDTH-1:0]              out_req_addr,
  output logic [DW-1:0]                      out_req_data,
  output logic [DATA_SIZE-1:0]               out_req_byteen,
  output logic [OTW-1:0]                     out_req_tag,
  input  logic                               out_rsp_valid,
  output logic                               out_rsp_ready,
  input  logic [DW-1:0]                      out_rsp_data,
  input  logic [OTW-1:0]                     out_rsp_tag,
  output logic [NUM_INPUTS-1:0]              pending_full
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [NUM_INPUTS*32-1:0]           perf_grants,
  output logic [NUM_INPUTS*32-1:0]           perf_stalls
`endif
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] MAXP = PW'(MAX_PENDING);

  typedef logic [LOG_N-1:0] idx_t;

  logic [PW-1:0]           pending [NUM_INPUTS];
  idx_t                    rr_ptr, cur_grant, sel, sel_scan, scan_start;
  logic [WEIGHT_WIDTH-1:0] burst_cnt, cnt_eff, sel_w;
  logic [NUM_INPUTS-1:0]   elig, inc, dec;
  logic                    keep, broken, fire_in, burst_done;
  logic                    rsp_fire, idx_ok;
  idx_t                    rsp_idx;

  function automatic idx_t wrap_inc(input idx_t x);
    return (x == idx_t'(NUM_INPUTS - 1)) ? '0 : x + 1'b1;
  endfunction

  // Eligibility: writes always pass, reads need a free pending slot.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      elig[i] = in_req_valid[i] & (in_req_rw[i] | (pending[i] < MAXP));
      pending_full[i] = (pending[i] == MAXP);
    end
  end

  assign keep   = (burst_cnt != '0) & elig[cur_grant];
  assign broken = (burst_cnt != '0) & ~elig[cur_grant];
  assign scan_start = broken ? wrap_inc(cur_grant) : rr_ptr;

  // First eligible input scanning upward from scan_start.
  always_comb begin
    int j;
    logic found;
    j = 0;
    found = 1'b0;
    sel_scan = scan_start;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      j = int'(scan_start) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
      if (!found && elig[j]) begin
        found = 1'b1;
        sel_scan = idx_t'(j);
      end
    end
  end

  assign sel        = keep ? cur_grant : sel_scan;
  assign sel_w      = weights[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign cnt_eff    = (sel == cur_grant) ? burst_cnt : '0;
  assign burst_done = (cnt_eff == sel_w);
  assign fire_in    = reset & (~out_req_valid | out_req_ready) & (|elig);

  // One-hot ready toward the granted requester.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_req_ready[i] = fire_in & (sel == idx_t'(i));
      inc[i] = in_req_ready[i] & ~in_req_rw[i];
      dec[i] = rsp_fire & idx_ok & (rsp_idx == idx_t'(i));
    end
  end

  // Burst and round-robin pointer bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cur_grant <= '0;
      burst_cnt <= '0;
    end else if (fire_in) begin
      cur_grant <= sel;
      if (burst_done) begin
        burst_cnt <= '0;
        rr_ptr    <= wrap_inc(sel);
      end else begin
        burst_cnt <= cnt_eff + 1'b1;
        if (broken) rr_ptr <= wrap_inc(cur_grant);
      end
    end else if (broken) begin
      burst_cnt <= '0;
      rr_ptr    <= wrap_inc(cur_grant);
    end
  end

  // Single output slot, held while the memory bus stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_req_valid  <= 1'b0;
      out_req_rw     <= 1'b0;
      out_req_addr   <= '0;
      out_req_data   <= '0;
      out_req_byteen <= '0;
      out_req_tag    <= '0;
    end else if (fire_in) begin
      out_req_valid  <= 1'b1;
      out_req_rw     <= in_req_rw[sel];
      out_req_addr   <= in_req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
      out_req_data   <= in_req_data[sel*DW +: DW];
      out_req_byteen <= in_req_byteen[sel*DATA_SIZE +: DATA_SIZE];
      out_req_tag    <= {in_req_tag[sel*TAG_WIDTH +: TAG_WIDTH], sel};
    end else if (out_req_ready) begin
      out_req_valid  <= 1'b0;
    end
  end

  // Outstanding-read counters per input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (inc[i] && !dec[i]) pending[i] <= pending[i] + 1'b1;
        else if (dec[i] && !inc[i]) pending[i] <= pending[i] - 1'b1;
      end
    end
  end

  assign rsp_idx     = out_rsp_tag[LOG_N-1:0];
  assign idx_ok      = (int'(rsp_idx) < NUM_INPUTS);
  assign rsp_fire    = out_rsp_valid & out_rsp_ready;
  assign in_rsp_data = out_rsp_data;
  assign in_rsp_tag  = out_rsp_tag[OTW-1:LOG_N];

  // Route responses back by the appended index bits.
  always_comb begin
    out_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_rsp_valid[i] = out_rsp_valid & (rsp_idx == idx_t'(i));
      if (rsp_idx == idx_t'(i)) out_rsp_ready = in_rsp_ready[i];
    end
  end

`ifndef SYNTHESIS
  // Catch protocol misuse in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        assert (!(dec[i] && pending[i] == '0))
          else $error("pending underflow on input %0d", i);
      assert (!(out_rsp_valid && !idx_ok))
        else $error("response index %0d out of range", rsp_idx);
    end
  end
`endif

`ifdef VX_MEM_ARB_PERF_EN
  // Per-input grant and stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (in_req_ready[i])
          perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
        if (in_req_valid[i] && !in_req_ready[i])
          perf_stalls[i*32 +: 32] <= perf_stalls[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule
